// File: rtl/clock_audio_pkg.sv
// clock_audio_pkg: note half-periods, source encodings and sequence lengths shared by the audio blocks
package clock_audio_pkg;
  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_KEY   = 2'd1,
    SRC_CHIME = 2'd2,
    SRC_ALARM = 2'd3
  } src_e;
  localparam int L_1 = 127552;
  localparam int L_2 = 113636;
  localparam int L_3 = 101236;
  localparam int L_4 = 95548;
  localparam int L_5 = 85136;
  localparam int L_6 = 75838;
  localparam int L_7 = 67567;
  localparam int M_1 = 63776;
  localparam int M_2 = 56818;
  localparam int M_3 = 50607;
  localparam int M_4 = 47778;
  localparam int M_5 = 42553;
  localparam int M_6 = 37936;
  localparam int M_7 = 33783;
  localparam int CHIME_LEN = 4;
  localparam int ALARM_LEN = 14;
endpackage

// File: rtl/beep_scheduler_tone_gen.sv
// tone_gen: square-wave buzzer drive toggling every half_period+1 cycles, phase-aligned to each new note
module tone_gen #(
  parameter int HP_W = 18
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [HP_W-1:0] half_period,
  output logic            beep
);
  logic [HP_W-1:0] cnt_q, cnt_d, hp_q, cnt_eff;
  logic beep_q, beep_d, same, beep_eff;
  // a note change is treated as count 0 / beep low in the same cycle so every note starts aligned
  always_comb begin
    same     = half_period == hp_q;
    cnt_eff  = same ? cnt_q : '0;
    beep_eff = same && half_period != '0 && beep_q;
    cnt_d    = (half_period == '0 || cnt_eff == half_period) ? '0 : cnt_eff + 1'b1;
    beep_d   = half_period == '0 ? 1'b0 : (cnt_eff == half_period ? ~beep_eff : beep_eff);
  end
  // counter, output phase and last-seen half-period registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      hp_q   <= '0;
      beep_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hp_q   <= half_period;
      beep_q <= beep_d;
    end
  end
  assign beep = beep_eff;
endmodule

// File: rtl/beep_scheduler.sv
// beep_scheduler: fixed-priority arbiter and note sequencer sharing one buzzer between key, chime and alarm
module beep_scheduler
  import clock_audio_pkg::*;
#(
  parameter int NOTE_TICKS    = 50000000,
  parameter int CLICK_TICKS   = 5000000,
  parameter int ALARM_REPEATS = 3,
  parameter int HP_W          = 18
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            key_req,
  input  logic            chime_req,
  input  logic            alarm_req,
  input  logic            alarm_stop,
  output logic            busy,
  output logic [1:0]      active_src,
  output logic [HP_W-1:0] half_period,
  output logic            beep,
  output logic            sd
);
  localparam logic [25:0] NOTE_LAST  = 26'(NOTE_TICKS - 1);
  localparam logic [25:0] CLICK_LAST = 26'(CLICK_TICKS - 1);
  localparam logic [3:0]  REP_LAST   = 4'(ALARM_REPEATS - 1);
  localparam logic [3:0]  CHIME_LAST = 4'(CHIME_LEN - 1);
  localparam logic [3:0]  ALARM_LAST = 4'(ALARM_LEN - 1);

  function automatic logic [HP_W-1:0] chime_note(input logic [3:0] i);
    logic [HP_W-1:0] n;
    case (i)
      4'd0:    n = HP_W'(M_5);
      4'd1:    n = HP_W'(M_3);
      4'd2:    n = HP_W'(M_1);
      default: n = HP_W'(L_5);
    endcase
    return n;
  endfunction

  function automatic logic [HP_W-1:0] alarm_note(input logic [3:0] i);
    logic [HP_W-1:0] n;
    case (i)
      4'd0:    n = HP_W'(L_1);
      4'd1:    n = HP_W'(L_2);
      4'd2:    n = HP_W'(L_3);
      4'd3:    n = HP_W'(L_4);
      4'd4:    n = HP_W'(L_5);
      4'd5:    n = HP_W'(L_6);
      4'd6:    n = HP_W'(L_7);
      4'd7:    n = HP_W'(M_1);
      4'd8:    n = HP_W'(M_2);
      4'd9:    n = HP_W'(M_3);
      4'd10:   n = HP_W'(M_4);
      4'd11:   n = HP_W'(M_5);
      4'd12:   n = HP_W'(M_6);
      default: n = HP_W'(M_7);
    endcase
    return n;
  endfunction

  src_e        state_q, state_d, eff;
  logic [25:0] timer_q, timer_d;
  logic [3:0]  idx_q, idx_d, rep_q, rep_d;
  logic        note_end;

  // sequencing of the current source, then request arbitration overriding it (alarm > chime > key)
  always_comb begin
    eff      = (state_q == SRC_ALARM && alarm_stop) ? SRC_NONE : state_q;
    note_end = timer_q == NOTE_LAST;
    state_d  = eff;
    timer_d  = '0;
    idx_d    = '0;
    rep_d    = '0;
    if (eff == SRC_KEY) begin
      state_d = timer_q == CLICK_LAST ? SRC_NONE : SRC_KEY;
      timer_d = timer_q == CLICK_LAST ? '0 : timer_q + 1'b1;
    end else if (eff == SRC_CHIME) begin
      timer_d = note_end ? '0 : timer_q + 1'b1;
      idx_d   = !note_end ? idx_q : (idx_q == CHIME_LAST ? '0 : idx_q + 1'b1);
      state_d = (note_end && idx_q == CHIME_LAST) ? SRC_NONE : SRC_CHIME;
    end else if (eff == SRC_ALARM) begin
      timer_d = note_end ? '0 : timer_q + 1'b1;
      idx_d   = !note_end ? idx_q : (idx_q == ALARM_LAST ? '0 : idx_q + 1'b1);
      rep_d   = (note_end && idx_q == ALARM_LAST) ? (rep_q == REP_LAST ? '0 : rep_q + 1'b1) : rep_q;
      state_d = (note_end && idx_q == ALARM_LAST && rep_q == REP_LAST) ? SRC_NONE : SRC_ALARM;
    end
    if ((alarm_req && state_q != SRC_ALARM) || (chime_req && eff != SRC_ALARM) ||
        (key_req && (eff == SRC_NONE || eff == SRC_KEY))) begin
      state_d = (alarm_req && state_q != SRC_ALARM) ? SRC_ALARM :
                (chime_req && eff != SRC_ALARM)     ? SRC_CHIME : SRC_KEY;
      timer_d = '0;
      idx_d   = '0;
      rep_d   = '0;
    end
  end

  // state, beat timer, note index and repeat count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SRC_NONE;
      timer_q <= '0;
      idx_q   <= '0;
      rep_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
    end
  end

  // outputs follow the registered state so reset clears them without a clock
  always_comb begin
    busy        = state_q != SRC_NONE;
    sd          = busy;
    active_src  = state_q;
    half_period = state_q == SRC_KEY   ? HP_W'(M_1) :
                  state_q == SRC_CHIME ? chime_note(idx_q) :
                  state_q == SRC_ALARM ? alarm_note(idx_q) : '0;
  end

  tone_gen #(.HP_W(HP_W)) u_tone (
    .clk         (clk),
    .rst         (rst),
    .half_period (half_period),
    .beep        (beep)
  );
endmodule

// File: tb/tb_beep_scheduler.sv
// tb_beep_scheduler: directed checks of arbitration, note sequencing, preemption, reset and tone toggling
module tb_beep_scheduler;
  logic clk = 0, rst = 1;
  logic key_req = 0, chime_req = 0, alarm_req = 0, alarm_stop = 0;
  logic busy, sd, beep, tg_beep;
  logic [1:0] active_src;
  logic [17:0] half_period, hp_tb = '0, exp_hp;
  int checks = 0, errors = 0;
  int chime_tbl[4] = '{42553, 50607, 63776, 85136};
  int alarm_tbl[14] = '{127552, 113636, 101236, 95548, 85136, 75838, 67567,
                        63776, 56818, 50607, 47778, 42553, 37936, 33783};

  beep_scheduler #(.NOTE_TICKS(20), .CLICK_TICKS(8), .ALARM_REPEATS(2), .HP_W(18)) dut (
    .clk(clk), .rst(rst), .key_req(key_req), .chime_req(chime_req), .alarm_req(alarm_req),
    .alarm_stop(alarm_stop), .busy(busy), .active_src(active_src), .half_period(half_period),
    .beep(beep), .sd(sd)
  );

  tone_gen #(.HP_W(18)) tg (.clk(clk), .rst(rst), .half_period(hp_tb), .beep(tg_beep));

  always #5 clk = ~clk;

  task automatic pulse(input logic k, input logic c, input logic a, input logic s);
    key_req = k; chime_req = c; alarm_req = a; alarm_stop = s;
    @(negedge clk);
    key_req = 0; chime_req = 0; alarm_req = 0; alarm_stop = 0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({busy, sd, beep, active_src, half_period} !== '0) begin
      errors++;
      $display("FAIL reset: busy=%b sd=%b beep=%b src=%0d hp=%0d, want all 0", busy, sd, beep, active_src, half_period);
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_key;
    pulse(1, 0, 0, 0);
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (active_src !== 2'd1 || half_period !== 18'd63776 || busy !== 1'b1) begin
        errors++;
        $display("FAIL key c=%0d: src=%0d hp=%0d busy=%b, want 1 63776 1", c, active_src, half_period, busy);
      end
      tick(1);
    end
    checks++;
    if ({busy, sd, beep, active_src, half_period} !== '0) begin
      errors++;
      $display("FAIL key_end: busy=%b sd=%b beep=%b src=%0d hp=%0d, want all 0", busy, sd, beep, active_src, half_period);
    end
  endtask

  task automatic test_key_retrigger;
    pulse(1, 0, 0, 0);
    tick(5);
    pulse(1, 0, 0, 0);
    tick(7);
    checks++;
    if (active_src !== 2'd1 || half_period !== 18'd63776) begin
      errors++;
      $display("FAIL key_retrig_hold: src=%0d hp=%0d, want 1 63776", active_src, half_period);
    end
    tick(1);
    checks++;
    if (busy !== 1'b0 || active_src !== 2'd0) begin
      errors++;
      $display("FAIL key_retrig_end: busy=%b src=%0d, want 0 0", busy, active_src);
    end
  endtask

  task automatic test_chime;
    pulse(0, 1, 0, 0);
    for (int c = 0; c < 80; c++) begin
      exp_hp = 18'(chime_tbl[c / 20]);
      checks++;
      if (active_src !== 2'd2 || half_period !== exp_hp) begin
        errors++;
        $display("FAIL chime c=%0d: src=%0d hp=%0d, want 2 %0d", c, active_src, half_period, exp_hp);
      end
      tick(1);
    end
    checks++;
    if (busy !== 1'b0 || sd !== 1'b0 || half_period !== 18'd0) begin
      errors++;
      $display("FAIL chime_end: busy=%b sd=%b hp=%0d, want 0 0 0", busy, sd, half_period);
    end
  endtask

  task automatic test_alarm;
    pulse(0, 0, 1, 0);
    for (int c = 0; c < 560; c++) begin
      exp_hp = 18'(alarm_tbl[(c / 20) % 14]);
      checks++;
      if (active_src !== 2'd3 || half_period !== exp_hp) begin
        errors++;
        $display("FAIL alarm c=%0d: src=%0d hp=%0d, want 3 %0d", c, active_src, half_period, exp_hp);
      end
      tick(1);
    end
    checks++;
    if (busy !== 1'b0 || active_src !== 2'd0 || half_period !== 18'd0) begin
      errors++;
      $display("FAIL alarm_end: busy=%b src=%0d hp=%0d, want 0 0 0", busy, active_src, half_period);
    end
  endtask

  task automatic test_tone;
    hp_tb = 18'd3;
    #1;
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (tg_beep !== 1'((k / 4) % 2)) begin
        errors++;
        $display("FAIL tone k=%0d: beep=%b, want %0d", k, tg_beep, (k / 4) % 2);
      end
      @(negedge clk);
      #1;
    end
    hp_tb = 18'd0;
    tick(3);
    checks++;
    if (tg_beep !== 1'b0) begin
      errors++;
      $display("FAIL tone_silent: beep=%b, want 0", tg_beep);
    end
  endtask

  task automatic test_preempt;
    pulse(0, 1, 0, 0);
    tick(5);
    pulse(0, 0, 1, 0);
    checks++;
    if (active_src !== 2'd3 || half_period !== 18'd127552) begin
      errors++;
      $display("FAIL preempt: src=%0d hp=%0d, want 3 127552", active_src, half_period);
    end
    tick(24);
    pulse(0, 0, 1, 0);
    checks++;
    if (active_src !== 2'd3 || half_period !== 18'd113636) begin
      errors++;
      $display("FAIL alarm_retrig_ignored: src=%0d hp=%0d, want 3 113636", active_src, half_period);
    end
    pulse(1, 0, 0, 0);
    checks++;
    if (active_src !== 2'd3 || half_period !== 18'd113636) begin
      errors++;
      $display("FAIL key_in_alarm: src=%0d hp=%0d, want 3 113636", active_src, half_period);
    end
    pulse(0, 0, 0, 1);
    checks++;
    if (busy !== 1'b0 || active_src !== 2'd0) begin
      errors++;
      $display("FAIL stop_no_resume: busy=%b src=%0d, want 0 0", busy, active_src);
    end
    tick(3);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL chime_resumed: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_same_cycle;
    pulse(0, 0, 1, 1);
    checks++;
    if (active_src !== 2'd3 || half_period !== 18'd127552) begin
      errors++;
      $display("FAIL idle_alarm_and_stop: src=%0d hp=%0d, want 3 127552", active_src, half_period);
    end
    tick(3);
    pulse(1, 1, 0, 1);
    checks++;
    if (active_src !== 2'd2 || half_period !== 18'd42553) begin
      errors++;
      $display("FAIL stop_with_chime_key: src=%0d hp=%0d, want 2 42553", active_src, half_period);
    end
    tick(80);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_end: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_reset_mid_alarm;
    pulse(0, 0, 1, 0);
    tick(3);
    @(posedge clk);
    #2;
    rst = 1;
    #1;
    checks++;
    if ({busy, sd, beep, active_src, half_period} !== '0) begin
      errors++;
      $display("FAIL async_reset: busy=%b sd=%b beep=%b src=%0d hp=%0d, want all 0", busy, sd, beep, active_src, half_period);
    end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    pulse(1, 0, 0, 0);
    checks++;
    if (active_src !== 2'd1 || half_period !== 18'd63776) begin
      errors++;
      $display("FAIL key_after_reset: src=%0d hp=%0d, want 1 63776", active_src, half_period);
    end
    tick(8);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL key_after_reset_end: busy=%b, want 0", busy);
    end
  endtask

  initial begin
    test_reset;
    test_key;
    test_key_retrigger;
    test_chime;
    test_alarm;
    test_tone;
    test_preempt;
    test_same_cycle;
    test_reset_mid_alarm;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
